// File: rtl/tx_scheduler_if.sv
// Handshake bundle between the RF/ALU result sources, the UART transmitter and tx_scheduler.
// slave is the scheduler's view; master is the view of whatever drives the sources and the UART.
interface tx_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   RF_RD_Data;
    logic                    RF_RD_Valid;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_Valid;
    logic                    TX_Busy;
    logic [DATA_WIDTH-1:0]   TX_P_Data;
    logic                    TX_Data_Valid;
    logic                    Sched_Busy;
    logic                    OVF;

    modport master (
        output RF_RD_Data, RF_RD_Valid, ALU_OUT, ALU_OUT_Valid, TX_Busy,
        input  TX_P_Data, TX_Data_Valid, Sched_Busy, OVF
    );

    modport slave (
        input  RF_RD_Data, RF_RD_Valid, ALU_OUT, ALU_OUT_Valid, TX_Busy,
        output TX_P_Data, TX_Data_Valid, Sched_Busy, OVF
    );
endinterface

// File: rtl/tx_scheduler.sv
// Arbitrates RF bytes and two-byte ALU results onto a UART transmitter, with busy-timeout re-issue.
// Define TX_SCHED_RR_EN for round-robin tie-breaking; otherwise RF always wins a tie.
module tx_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int BUSY_WAIT  = 15
) (
    input  logic          CLK,
    input  logic          RST,
    tx_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(BUSY_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [DATA_WIDTH-1:0]   rf_buf_r;
    logic                    rf_pend_r;
    logic [2*DATA_WIDTH-1:0] alu_buf_r;
    logic                    alu_pend_r;
    logic [DATA_WIDTH-1:0]   msb_buf_r;
    logic                    msb_due_r;
    logic [CNT_W-1:0]        tmo_cnt_r;
    logic [DATA_WIDTH-1:0]   tx_data_r;
    logic                    tx_valid_r;
    logic                    ovf_r;
    logic                    any_pend_s;
    logic                    rf_wins_s;
    logic                    grant_rf_s;
    logic                    grant_alu_s;
    logic                    load_msb_s;

    assign any_pend_s = rf_pend_r | alu_pend_r;

`ifdef TX_SCHED_RR_EN
    logic last_alu_r;
    assign rf_wins_s = rf_pend_r & (~alu_pend_r | last_alu_r);

    // Remember which source was granted last so a tie goes to the other one
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_alu_r <= 1'b1;
        end else if (grant_rf_s) begin
            last_alu_r <= 1'b0;
        end else if (grant_alu_s) begin
            last_alu_r <= 1'b1;
        end
    end
`else
    assign rf_wins_s = rf_pend_r;
`endif

    // Next-state and grant decode
    always_comb begin
        state_nxt_s = state_r;
        grant_rf_s  = 1'b0;
        grant_alu_s = 1'b0;
        load_msb_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_pend_s && !bus.TX_Busy) begin
                    state_nxt_s = SEND;
                    if (rf_wins_s) begin
                        grant_rf_s = 1'b1;
                    end else begin
                        grant_alu_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                state_nxt_s = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.TX_Busy) begin
                    state_nxt_s = WAIT_LO;
                end else if (tmo_cnt_r >= CNT_LAST) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (bus.TX_Busy) begin
                    state_nxt_s = WAIT_LO;
                end else if (msb_due_r) begin
                    // second half of an ALU result goes out before anything else is granted
                    state_nxt_s = SEND;
                    load_msb_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Holding buffers; a strobe into a still-pending, ungranted buffer is dropped
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rf_buf_r   <= '0;
            rf_pend_r  <= 1'b0;
            alu_buf_r  <= '0;
            alu_pend_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (bus.RF_RD_Valid && (!rf_pend_r || grant_rf_s)) begin
                rf_buf_r  <= bus.RF_RD_Data;
                rf_pend_r <= 1'b1;
            end else if (grant_rf_s) begin
                rf_pend_r <= 1'b0;
            end
            if (bus.ALU_OUT_Valid && (!alu_pend_r || grant_alu_s)) begin
                alu_buf_r  <= bus.ALU_OUT;
                alu_pend_r <= 1'b1;
            end else if (grant_alu_s) begin
                alu_pend_r <= 1'b0;
            end
            ovf_r <= ovf_r
                   | (bus.RF_RD_Valid   & rf_pend_r  & ~grant_rf_s)
                   | (bus.ALU_OUT_Valid & alu_pend_r & ~grant_alu_s);
        end
    end

    // FSM state, output byte register and busy-timeout counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r    <= IDLE;
            tx_data_r  <= '0;
            tx_valid_r <= 1'b0;
            msb_buf_r  <= '0;
            msb_due_r  <= 1'b0;
            tmo_cnt_r  <= '0;
        end else begin
            state_r    <= state_nxt_s;
            tx_valid_r <= (state_nxt_s == SEND);
            if (grant_rf_s) begin
                tx_data_r <= rf_buf_r;
            end else if (grant_alu_s) begin
                // the MSB is captured now because alu_buf may be refilled mid-transfer
                tx_data_r <= alu_buf_r[DATA_WIDTH-1:0];
                msb_buf_r <= alu_buf_r[2*DATA_WIDTH-1:DATA_WIDTH];
                msb_due_r <= 1'b1;
            end else if (load_msb_s) begin
                tx_data_r <= msb_buf_r;
                msb_due_r <= 1'b0;
            end
            if (state_r == SEND) begin
                tmo_cnt_r <= '0;
            end else if ((state_r == WAIT_HI) && (tmo_cnt_r != CNT_MAX)) begin
                tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.TX_P_Data     = tx_data_r;
    assign bus.TX_Data_Valid = tx_valid_r;
    assign bus.OVF           = ovf_r;
    assign bus.Sched_Busy    = rf_pend_r | alu_pend_r | (state_r != IDLE);
endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: a transaction-level model predicts the byte stream and OVF,
// a negedge monitor checks every TX_Data_Valid pulse against the expected-byte queue.
module tb_tx_scheduler;
    localparam int DW = 8;
    localparam int BW = 15;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    tx_scheduler_if #(.DATA_WIDTH(DW)) bus ();
    tx_scheduler #(.DATA_WIDTH(DW), .BUSY_WAIT(BW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_e;

    logic resp_en   = 1'b0;
    logic resp_busy = 1'b0;
    logic man_busy  = 1'b0;
    assign bus.TX_Busy = resp_en ? resp_busy : man_busy;

    // reference model: pending requests per source and who was served last
    bit            m_rf_p, m_alu_p, m_last_alu, m_ovf;
    logic [DW-1:0]   m_rf_v;
    logic [2*DW-1:0] m_alu_v;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every byte handed to the UART must be the next one the model predicted
    always @(negedge CLK) begin
        if (bus.TX_Data_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h, expected no byte (cycle %0d)", bus.TX_P_Data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("tx_byte", {24'h0, bus.TX_P_Data}, {24'h0, mon_e});
            end
        end
    end

    // UART stand-in: busy rises 1..4 cycles after a byte is offered and stays up 2..8 cycles
    initial begin
        forever begin
            @(negedge CLK);
            if (resp_en && bus.TX_Data_Valid === 1'b1) begin
                repeat ($urandom_range(4, 1)) @(negedge CLK);
                resp_busy = 1'b1;
                repeat ($urandom_range(8, 2)) @(negedge CLK);
                resp_busy = 1'b0;
            end
        end
    end

    function automatic bit model_pick_rf();
        if (m_rf_p && m_alu_p) begin
`ifdef TX_SCHED_RR_EN
            return m_last_alu;
`else
            return 1'b1;
`endif
        end
        return m_rf_p;
    endfunction

    task automatic model_strobe(input bit is_rf, input logic [2*DW-1:0] v);
        if (is_rf) begin
            if (m_rf_p) m_ovf = 1'b1;
            else begin m_rf_p = 1'b1; m_rf_v = v[DW-1:0]; end
        end else begin
            if (m_alu_p) m_ovf = 1'b1;
            else begin m_alu_p = 1'b1; m_alu_v = v; end
        end
    endtask

    // serve pending requests in arbitration order; one_only stops after the first grant
    task automatic model_drain(input bit one_only);
        while (m_rf_p || m_alu_p) begin
            if (model_pick_rf()) begin
                exp_q.push_back(m_rf_v);
                m_rf_p = 1'b0;
                m_last_alu = 1'b0;
            end else begin
                exp_q.push_back(m_alu_v[DW-1:0]);
                exp_q.push_back(m_alu_v[2*DW-1:DW]);
                m_alu_p = 1'b0;
                m_last_alu = 1'b1;
            end
            if (one_only) break;
        end
    endtask

    task automatic model_reset();
        m_rf_p = 1'b0; m_alu_p = 1'b0; m_last_alu = 1'b1; m_ovf = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        RST = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic strobe(input bit rf, input bit alu, input logic [DW-1:0] rv, input logic [2*DW-1:0] av);
        bus.RF_RD_Valid   = rf;
        bus.RF_RD_Data    = rv;
        bus.ALU_OUT_Valid = alu;
        bus.ALU_OUT       = av;
        @(negedge CLK);
        bus.RF_RD_Valid   = 1'b0;
        bus.ALU_OUT_Valid = 1'b0;
    endtask

    task automatic wait_dv(input string name, output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (bus.TX_Data_Valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: TX_Data_Valid absent, expected within 200 cycles", name);
        end
    endtask

    task automatic wait_idle(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (bus.Sched_Busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'h0, seen}, 32'h1);
    endtask

    // one arbitration round; extra (1=RF, 2=ALU) strobes again right after the first byte goes out
    task automatic run_txn(input logic [1:0] mask, input logic [DW-1:0] rv, input logic [2*DW-1:0] av,
                           input int extra, input logic [2*DW-1:0] ev);
        int t;
        if (mask[0]) model_strobe(1'b1, {8'h0, rv});
        if (mask[1]) model_strobe(1'b0, av);
        model_drain(1'b1);
        if (extra != 0) model_strobe(extra == 1, ev);
        model_drain(1'b0);
        strobe(mask[0], mask[1], rv, av);
        if (extra != 0) begin
            wait_dv("txn_first_byte", t);
            strobe(extra == 1, extra == 2, ev[DW-1:0], ev);
        end
        wait_idle("txn_idle");
        chk("txn_drained", exp_q.size(), 0);
        chk("txn_ovf", {31'h0, bus.OVF}, {31'h0, m_ovf});
    endtask

    initial begin
        int t0, t1, t2;
        bus.RF_RD_Valid = 1'b0; bus.RF_RD_Data = '0;
        bus.ALU_OUT_Valid = 1'b0; bus.ALU_OUT = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("rst_data",  {24'h0, bus.TX_P_Data}, 32'h0);
        chk("rst_valid", {31'h0, bus.TX_Data_Valid}, 32'h0);
        chk("rst_busy",  {31'h0, bus.Sched_Busy}, 32'h0);
        chk("rst_ovf",   {31'h0, bus.OVF}, 32'h0);
        RST = 1'b1;
        @(negedge CLK);

        // single RF byte, busy held 10 cycles
        model_strobe(1'b1, 16'h00A5); model_drain(1'b0);
        strobe(1'b1, 1'b0, 8'hA5, 16'h0);
        wait_dv("r031_dv", t0);
        repeat (2) @(negedge CLK);
        man_busy = 1'b1;
        repeat (10) @(negedge CLK);
        man_busy = 1'b0;
        chk("r031_busy_hold", {31'h0, bus.Sched_Busy}, 32'h1);
        @(negedge CLK);
        chk("r031_busy_fall", {31'h0, bus.Sched_Busy}, 32'h0);
        chk("r031_data_hold", {24'h0, bus.TX_P_Data}, 32'hA5);

        // ALU result: LSB then MSB, MSB offered one cycle after busy falls
        model_strobe(1'b0, 16'h1234); model_drain(1'b0);
        strobe(1'b0, 1'b1, 8'h0, 16'h1234);
        wait_dv("r032_lsb", t0);
        @(negedge CLK); man_busy = 1'b1;
        repeat (5) @(negedge CLK); man_busy = 1'b0;
        @(negedge CLK);
        chk("r032_msb_latency", {31'h0, bus.TX_Data_Valid}, 32'h1);
        @(negedge CLK); man_busy = 1'b1;
        repeat (4) @(negedge CLK); man_busy = 1'b0;
        wait_idle("r032_idle");

        // busy never rises: same byte re-offered every BW+1 cycles
        model_strobe(1'b1, 16'h003C); model_drain(1'b0);
        exp_q.push_back(8'h3C); exp_q.push_back(8'h3C);
        strobe(1'b1, 1'b0, 8'h3C, 16'h0);
        wait_dv("r035_dv0", t0);
        wait_dv("r035_dv1", t1);
        wait_dv("r035_dv2", t2);
        man_busy = 1'b1;
        chk("r035_period1", t1 - t0, BW + 1);
        chk("r035_period2", t2 - t1, BW + 1);
        repeat (3) @(negedge CLK); man_busy = 1'b0;
        wait_idle("r035_idle");
        chk("r035_drained", exp_q.size(), 0);

        // simultaneous RF and ALU after reset, then a tie with both pending again
        resp_en = 1'b1;
        do_reset();
        run_txn(2'b11, 8'h11, 16'hBEEF, 0, 16'h0);
        do_reset();
        run_txn(2'b11, 8'h11, 16'hBEEF, 1, 16'h0022);

        // overflow: second RF strobe 3 cycles after the first while it waits behind an ALU transfer
        do_reset();
        model_strobe(1'b0, 16'hCAFE); model_drain(1'b1);
        model_strobe(1'b1, 16'h0055);
        model_strobe(1'b1, 16'h0066);
        model_drain(1'b0);
        strobe(1'b0, 1'b1, 8'h0, 16'hCAFE);
        wait_dv("r034_dv", t0);
        strobe(1'b1, 1'b0, 8'h55, 16'h0);
        repeat (2) @(negedge CLK);
        strobe(1'b1, 1'b0, 8'h66, 16'h0);
        wait_idle("r034_idle");
        chk("r034_ovf", {31'h0, bus.OVF}, 32'h1);
        repeat (10) @(negedge CLK);
        chk("r034_ovf_sticky", {31'h0, bus.OVF}, 32'h1);
        chk("r034_drained", exp_q.size(), 0);

        // randomized rounds
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(3, 0) == 0) do_reset();
            run_txn(2'($urandom_range(3, 1)), 8'($urandom), 16'($urandom),
                    int'($urandom_range(2, 0)), 16'($urandom));
        end

        // reset in WAIT_LO between the ALU bytes: frame abandoned
        resp_en = 1'b0;
        man_busy = 1'b0;
        do_reset();
        model_strobe(1'b0, 16'hA1B2); model_drain(1'b0);
        strobe(1'b0, 1'b1, 8'h0, 16'hA1B2);
        wait_dv("r036_lsb", t0);
        @(negedge CLK); man_busy = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        #1;
        chk("r036_data",  {24'h0, bus.TX_P_Data}, 32'h0);
        chk("r036_valid", {31'h0, bus.TX_Data_Valid}, 32'h0);
        chk("r036_busy",  {31'h0, bus.Sched_Busy}, 32'h0);
        chk("r036_ovf",   {31'h0, bus.OVF}, 32'h0);
        @(negedge CLK); man_busy = 1'b0;
        @(negedge CLK); RST = 1'b1;
        repeat (40) @(negedge CLK);
        chk("r036_quiet", {31'h0, bus.Sched_Busy}, 32'h0);
        chk("final_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
